// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the edulent control sequencer: FSM states,
// control-word bit positions, opcode values and micro-ROM depth.
package control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT,
        ST_TRAP
    } state_t;

    localparam int CTRL_W = 8;

    // Bit positions inside the datapath control word
    localparam int CTRL_REG_RD  = 0;
    localparam int CTRL_REG_WE  = 1;
    localparam int CTRL_ADDR_LD = 2;
    localparam int CTRL_MEM_RD  = 3;
    localparam int CTRL_MEM_WR  = 4;
    localparam int CTRL_PC_INC  = 5;

    localparam logic [CTRL_W-1:0] CW_REG_RD  = CTRL_W'(1) << CTRL_REG_RD;
    localparam logic [CTRL_W-1:0] CW_REG_WE  = CTRL_W'(1) << CTRL_REG_WE;
    localparam logic [CTRL_W-1:0] CW_ADDR_LD = CTRL_W'(1) << CTRL_ADDR_LD;
    localparam logic [CTRL_W-1:0] CW_MEM_RD  = CTRL_W'(1) << CTRL_MEM_RD;
    localparam logic [CTRL_W-1:0] CW_MEM_WR  = CTRL_W'(1) << CTRL_MEM_WR;
    localparam logic [CTRL_W-1:0] CW_PC_INC  = CTRL_W'(1) << CTRL_PC_INC;

    // Opcodes known to the micro-ROM
    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_RMOV_11 = 8'h11;
    localparam logic [7:0] OP_RMOV_13 = 8'h13;
    localparam logic [7:0] OP_RMOV_19 = 8'h19;
    localparam logic [7:0] OP_RMOV_1B = 8'h1B;
    localparam logic [7:0] OP_RMOV_21 = 8'h21;
    localparam logic [7:0] OP_RMOV_23 = 8'h23;
    localparam logic [7:0] OP_MLD_14  = 8'h14;
    localparam logic [7:0] OP_MLD_1C  = 8'h1C;
    localparam logic [7:0] OP_MLD_1E  = 8'h1E;
    localparam logic [7:0] OP_MST_2C  = 8'h2C;
    localparam logic [7:0] OP_MST_2E  = 8'h2E;
    localparam logic [7:0] OP_HALT    = 8'h76;

    // Longest micro-program held in the ROM
    localparam int ROM_MAX_STEPS = 3;

endpackage

// File: rtl/control_sequencer_if.sv
// Bus between the memory/instruction-register side and the sequencer,
// together with the control outputs the sequencer drives to the datapath.
interface control_sequencer_if #(
    parameter int OPCODE_W = 8,
    parameter int STEP_W   = 2
);
    import control_pkg::*;

    logic [OPCODE_W-1:0] i_opcode;
    logic                i_mem_ready;
    logic                i_resume;
    logic [CTRL_W-1:0]   o_ctrl;
    logic [STEP_W-1:0]   o_step;
    logic                o_fetch;
    logic                next_instr;
    logic                o_halted;
    logic                o_illegal;

    modport master (
        input  i_opcode, i_mem_ready, i_resume,
        output o_ctrl, o_step, o_fetch, next_instr, o_halted, o_illegal
    );

    modport slave (
        output i_opcode, i_mem_ready, i_resume,
        input  o_ctrl, o_step, o_fetch, next_instr, o_halted, o_illegal
    );

endinterface

// File: rtl/control_sequencer_micro_rom.sv
// Combinational micro-ROM: opcode and EXEC step select a control word; the
// opcode alone gives the step count and whether it is a legal instruction.
module micro_rom
    import control_pkg::*;
#(
    parameter int OPCODE_W  = 8,
    parameter int MAX_STEPS = 4,
    parameter int STEP_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [STEP_W-1:0]   step,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [STEP_W:0]     n_steps,
    output logic                legal
);

    if (ROM_MAX_STEPS > MAX_STEPS) begin : g_rom_too_deep
        $error("micro_rom: a ROM entry needs %0d steps but MAX_STEPS is %0d",
               ROM_MAX_STEPS, MAX_STEPS);
    end

    // Table lookup; steps beyond an opcode's count read as an idle word
    always_comb begin
        ctrl    = '0;
        n_steps = '0;
        legal   = 1'b0;
        case (opcode)
            OPCODE_W'(OP_NOP): begin
                legal   = 1'b1;
                n_steps = (STEP_W+1)'(1);
            end
            OPCODE_W'(OP_RMOV_11), OPCODE_W'(OP_RMOV_13), OPCODE_W'(OP_RMOV_19),
            OPCODE_W'(OP_RMOV_1B), OPCODE_W'(OP_RMOV_21), OPCODE_W'(OP_RMOV_23): begin
                legal   = 1'b1;
                n_steps = (STEP_W+1)'(2);
                if (step == STEP_W'(0))      ctrl = CW_REG_RD;
                else if (step == STEP_W'(1)) ctrl = CW_REG_WE | CW_PC_INC;
            end
            OPCODE_W'(OP_MLD_14), OPCODE_W'(OP_MLD_1C), OPCODE_W'(OP_MLD_1E): begin
                legal   = 1'b1;
                n_steps = (STEP_W+1)'(3);
                if (step == STEP_W'(0))      ctrl = CW_ADDR_LD;
                else if (step == STEP_W'(1)) ctrl = CW_MEM_RD;
                else if (step == STEP_W'(2)) ctrl = CW_REG_WE | CW_PC_INC;
            end
            OPCODE_W'(OP_MST_2C), OPCODE_W'(OP_MST_2E): begin
                legal   = 1'b1;
                n_steps = (STEP_W+1)'(3);
                if (step == STEP_W'(0))      ctrl = CW_ADDR_LD;
                else if (step == STEP_W'(1)) ctrl = CW_MEM_WR;
                else if (step == STEP_W'(2)) ctrl = CW_REG_WE | CW_PC_INC;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer with memory wait-state stalls,
// HALT/resume and a sticky illegal-opcode trap. All outputs are registered.
module control_sequencer
    import control_pkg::*;
#(
    parameter int OPCODE_W  = 8,
    parameter int MAX_STEPS = 4,
    parameter int STEP_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    control_sequencer_if.master bus
);

    state_t              state;
    logic [OPCODE_W-1:0] ir;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   rom_step;
    logic [CTRL_W-1:0]   rom_ctrl;
    logic [STEP_W:0]     rom_n;
    logic                rom_legal;
    logic                mem_step;
    logic                last_step;

    // The ROM is addressed with the step about to be entered, so the
    // control word can be registered on the same edge the step changes.
    assign rom_step  = (state == ST_EXEC) ? step + STEP_W'(1) : '0;
    assign mem_step  = bus.o_ctrl[CTRL_MEM_RD] | bus.o_ctrl[CTRL_MEM_WR];
    assign last_step = ({1'b0, step} == rom_n - (STEP_W+1)'(1));
    assign bus.o_step = step;

    micro_rom #(
        .OPCODE_W  (OPCODE_W),
        .MAX_STEPS (MAX_STEPS),
        .STEP_W    (STEP_W)
    ) u_rom (
        .opcode  (ir),
        .step    (rom_step),
        .ctrl    (rom_ctrl),
        .n_steps (rom_n),
        .legal   (rom_legal)
    );

    // Sequencer state machine with registered control outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ST_FETCH;
            ir             <= '0;
            step           <= '0;
            bus.o_ctrl     <= '0;
            bus.o_fetch    <= 1'b1;
            bus.next_instr <= 1'b0;
            bus.o_halted   <= 1'b0;
            bus.o_illegal  <= 1'b0;
        end else begin
            bus.next_instr <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (bus.i_mem_ready) begin
                        ir          <= bus.i_opcode;
                        bus.o_fetch <= 1'b0;
                        state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (ir == OPCODE_W'(OP_HALT)) begin
                        bus.o_halted <= 1'b1;
                        state        <= ST_HALT;
                    end else if (!rom_legal) begin
                        bus.o_illegal <= 1'b1;
                        state         <= ST_TRAP;
                    end else begin
                        step       <= '0;
                        bus.o_ctrl <= rom_ctrl;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Memory steps hold until the access completes
                    if (!mem_step || bus.i_mem_ready) begin
                        if (last_step) begin
                            step           <= '0;
                            bus.o_ctrl     <= '0;
                            bus.o_fetch    <= 1'b1;
                            bus.next_instr <= 1'b1;
                            state          <= ST_FETCH;
                        end else begin
                            step       <= step + STEP_W'(1);
                            bus.o_ctrl <= rom_ctrl;
                        end
                    end
                end
                ST_HALT: begin
                    if (bus.i_resume) begin
                        bus.o_halted   <= 1'b0;
                        bus.o_fetch    <= 1'b1;
                        bus.next_instr <= 1'b1;
                        state          <= ST_FETCH;
                    end
                end
                ST_TRAP: begin
                    // Only reset leaves the trap
                    state <= ST_TRAP;
                end
                default: begin
                    step       <= '0;
                    bus.o_ctrl <= '0;
                    bus.o_fetch <= 1'b1;
                    state      <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multi-cycle control sequencer for the edulent CPU and successor to the single-step control unit. Runs a FETCH/DECODE/EXEC cycle per instruction with a per-opcode micro-step count from an internal micro-ROM. Stalls on memory wait states and supports HALT/resume and an illegal-opcode trap. Sits between the instruction register/memory interface and the datapath, driving one control word per cycle.

## Interface
Parameters:
- OPCODE_W, 8, opcode width
- MAX_STEPS, 4, maximum EXEC micro-steps per opcode; elaboration error if any ROM entry exceeds it
- STEP_W, $clog2(MAX_STEPS), width of the step counter

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_opcode  in  OPCODE_W  instruction byte from memory, valid when o_fetch && i_mem_ready
- i_mem_ready  in  1  memory completes the current access this cycle
- i_resume  in  1  leave HALT
- o_ctrl  out  CTRL_W  datapath control word; 0 outside EXEC
- o_step  out  STEP_W  current EXEC step index; 0 outside EXEC
- o_fetch  out  1  FETCH state active (memory read of opcode)
- next_instr  out  1  one-cycle pulse: instruction retired
- o_halted  out  1  HALT state
- o_illegal  out  1  sticky trap flag

## Operation
- States: FETCH, DECODE, EXEC, HALT, TRAP.
- FETCH:
  - o_fetch=1.
  - Waits while i_mem_ready=0.
  - On i_mem_ready=1: latch i_opcode into the IR and go to DECODE.
- DECODE (exactly 1 cycle):
  - ROM lookup of the IR gives the step count N and the control words.
  - HALT opcode 8'h76 → HALT.
  - Unknown opcode → TRAP.
  - Otherwise → EXEC with step=0.
- EXEC:
  - o_ctrl = ROM[IR][step].
  - Steps with CTRL_MEM_RD or CTRL_MEM_WR set hold the current step while i_mem_ready=0.
  - Any other step advances every cycle.
  - After step N-1 completes → FETCH.
- ROM contents:
  - 8'h00 NOP, N=1.
  - 8'h11/13/19/1B/21/23 register MOVs, N=2: step0 REG_RD, step1 REG_WE|PC_INC.
  - 8'h14/1C/1E/2C/2E memory MOVs, N=3: step0 ADDR_LD, step1 MEM_RD or MEM_WR, step2 REG_WE|PC_INC.
- HALT: o_halted=1; i_resume=1 → FETCH.
- TRAP: o_illegal=1, no fetches. Exit only by reset.
- next_instr: registered pulse, high for the one cycle after the EXEC→FETCH or HALT→FETCH transition; that cycle is the first FETCH cycle.
- Reset (any time, including mid-EXEC or a stalled memory step):
  - State=FETCH, IR=0, step=0.
  - All outputs 0 except o_fetch=1.
  - o_illegal cleared.

## Timing
- NOP with zero wait states is 3 cycles per instruction:
  - FETCH(c0), DECODE(c1), EXEC(c2).
  - next_instr=1 in c3, with FETCH of the next instruction.
- Register MOV: 4 cycles. Memory MOV: 5 cycles plus one cycle per i_mem_ready=0 cycle in FETCH or the memory step.
- Step counter increments only on step completion.
- The counter never wraps: the last step goes directly to FETCH and clears step to 0.
- i_resume, i_mem_ready and i_opcode are ignored in states where they are not consumed.

## Structure
- Package `control_pkg`:
  - `state_t` enum.
  - CTRL_W=8.
  - Control-bit index constants: CTRL_REG_RD=0, CTRL_REG_WE=1, CTRL_ADDR_LD=2, CTRL_MEM_RD=3, CTRL_MEM_WR=4, CTRL_PC_INC=5.
  - Opcode constants, including OP_HALT=8'h76.
- One sub-module `micro_rom` (combinational):
  - opcode, step → control word, step count N, legal flag.
  - Keeps the table separate from the FSM.

## Test plan
- Reset: assert i_rst mid-cycle → immediately o_fetch=1, o_ctrl=0, next_instr=0, o_illegal=0.
- NOP, i_mem_ready=1 → next_instr pulses every 3 cycles. Opcode 8'h11 → o_ctrl=REG_RD then REG_WE|PC_INC, and next_instr 4 cycles after FETCH.
- Opcode 8'h14, i_mem_ready=0 for 3 cycles at step1 → o_step stays 1 and o_ctrl stays MEM_RD for 4 cycles; next_instr 8 cycles after FETCH.
- Opcode 8'h76 → o_halted=1 with i_resume low for 10 cycles; i_resume=1 → FETCH next cycle, then a next_instr pulse.
- Opcode 8'hFF → o_illegal=1 and o_fetch=0, held for 20 cycles; i_rst clears both.
- Reset during a stalled memory step (8'h2C, step1) → FETCH with step=0; the next 8'h00 completes normally.
